// File: rtl/result_sram_arbiter.sv
// result_sram_arbiter: three-requester round-robin arbiter for a single-port result SRAM,
// with optional ownership locking bounded by BURST_MAX accepts.
//
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   req_valid/req_we/req_lock [2:0]     per-requester request, write select, lock hold
//   req_addr  [3*ADDR_W-1:0]            requester i address at [i*ADDR_W +: ADDR_W]
//   req_wdata [3*DATA_W-1:0]            requester i write data at [i*DATA_W +: DATA_W]
//   req_gnt   [2:0]                     combinational one-hot-or-zero grant
//   rsp_valid [2:0], rsp_data           read return, two cycles after the accept edge
//   dut__tb__sram_result_write_*        registered SRAM write port
//   dut__tb__sram_result_read_address   registered SRAM read address
//   tb__dut__sram_result_read_data      SRAM read data, one cycle after the address
module result_sram_arbiter #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            req_valid,
  input  logic [2:0]            req_we,
  input  logic [2:0]            req_lock,
  input  logic [3*ADDR_W-1:0]   req_addr,
  input  logic [3*DATA_W-1:0]   req_wdata,
  output logic [2:0]            req_gnt,
  output logic [2:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  dut__tb__sram_result_write_enable,
  output logic [ADDR_W-1:0]     dut__tb__sram_result_write_address,
  output logic [DATA_W-1:0]     dut__tb__sram_result_write_data,
  output logic [ADDR_W-1:0]     dut__tb__sram_result_read_address,
  input  logic [DATA_W-1:0]     tb__dut__sram_result_read_data
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  localparam logic [7:0] BurstMax = 8'(BURST_MAX);

  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  logic [0:0]        state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic [1:0]        rr_ptr_q, rr_ptr_d;
  logic [7:0]        burst_cnt_q, burst_cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  // One-hot requester tags for reads in flight: stage 1 while the SRAM samples the address,
  // stage 2 while the SRAM data is on the bus.
  logic [2:0]        tag1_q, tag1_d;
  logic [2:0]        tag2_q, tag2_d;
  logic [2:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;

  logic [2:0]        gnt;
  logic              acc;
  logic [1:0]        sel;
  logic [1:0]        c0, c1, c2;
  logic [2:0]        owner_mask;
  logic              others_valid;
  logic [7:0]        cnt_inc;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

  // Grant selection.
  always_comb begin
    gnt = '0;
    c0  = rr_ptr_q;
    c1  = inc3(rr_ptr_q);
    c2  = inc3(c1);
    if (state_q == StIdle) begin
      if (req_valid[c0]) begin
        gnt[c0] = 1'b1;
      end else if (req_valid[c1]) begin
        gnt[c1] = 1'b1;
      end else if (req_valid[c2]) begin
        gnt[c2] = 1'b1;
      end
    end else begin
      gnt[owner_q] = req_valid[owner_q];
    end
  end

  assign req_gnt = gnt;
  assign acc     = |gnt;
  assign sel     = gnt[1] ? 2'd1 : (gnt[2] ? 2'd2 : 2'd0);

  assign owner_mask   = 3'b001 << owner_q;
  assign others_valid = |(req_valid & ~owner_mask);
  assign cnt_inc      = (burst_cnt_q >= BurstMax) ? BurstMax : burst_cnt_q + 8'd1;

  assign addr_sel  = req_addr[sel*ADDR_W +: ADDR_W];
  assign wdata_sel = req_wdata[sel*DATA_W +: DATA_W];

  // Arbitration state.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    if (acc) begin
      rr_ptr_d = inc3(sel);
    end
    if (state_q == StIdle) begin
      if (acc && req_lock[sel]) begin
        state_d     = StLocked;
        owner_d     = sel;
        burst_cnt_d = 8'd1;
      end
    end else begin
      if (acc) begin
        burst_cnt_d = cnt_inc;
        // The accept that reaches the burst limit while someone else waits is the last one.
        if (!req_lock[owner_q] || ((cnt_inc == BurstMax) && others_valid)) begin
          state_d     = StIdle;
          burst_cnt_d = 8'd0;
        end
      end else if (!req_lock[owner_q]) begin
        state_d     = StIdle;
        burst_cnt_d = 8'd0;
      end
    end
  end

  // SRAM port and read-return pipeline.
  always_comb begin
    we_d        = acc & req_we[sel];
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    raddr_d     = raddr_q;
    tag1_d      = 3'b000;
    tag2_d      = tag1_q;
    rsp_valid_d = tag2_q;
    rsp_data_d  = rsp_data_q;
    if (we_d) begin
      waddr_d = addr_sel;
      wdata_d = wdata_sel;
    end
    if (acc && !req_we[sel]) begin
      raddr_d = addr_sel;
      tag1_d  = gnt;
    end
    if (|tag2_q) begin
      rsp_data_d = tb__dut__sram_result_read_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      owner_q     <= 2'd0;
      rr_ptr_q    <= 2'd0;
      burst_cnt_q <= 8'd0;
      we_q        <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_q     <= '0;
      tag1_q      <= 3'b000;
      tag2_q      <= 3'b000;
      rsp_valid_q <= 3'b000;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      we_q        <= we_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      raddr_q     <= raddr_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign rsp_valid                          = rsp_valid_q;
  assign rsp_data                           = rsp_data_q;
  assign dut__tb__sram_result_write_enable  = we_q;
  assign dut__tb__sram_result_write_address = waddr_q;
  assign dut__tb__sram_result_write_data    = wdata_q;
  assign dut__tb__sram_result_read_address  = raddr_q;

endmodule

// File: tb/tb_result_sram_arbiter.sv
// Directed bench for result_sram_arbiter with a behavioural SRAM and a read-return scoreboard.
module tb_result_sram_arbiter;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;
  localparam int unsigned BM = 4;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [2:0]      req_valid, req_we, req_lock;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      req_gnt, rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            sram_we;
  logic [AW-1:0]   sram_waddr, sram_raddr;
  logic [DW-1:0]   sram_wdata, sram_rdata;

  result_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk                                (clk),
    .reset_n                            (reset_n),
    .req_valid                          (req_valid),
    .req_we                             (req_we),
    .req_lock                           (req_lock),
    .req_addr                           (req_addr),
    .req_wdata                          (req_wdata),
    .req_gnt                            (req_gnt),
    .rsp_valid                          (rsp_valid),
    .rsp_data                           (rsp_data),
    .dut__tb__sram_result_write_enable  (sram_we),
    .dut__tb__sram_result_write_address (sram_waddr),
    .dut__tb__sram_result_write_data    (sram_wdata),
    .dut__tb__sram_result_read_address  (sram_raddr),
    .tb__dut__sram_result_read_data     (sram_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(input logic [7:0] a);
    return 32'hC0DE_0000 | {24'h0, a};
  endfunction

  // SRAM model: synchronous write, registered read one cycle after the address.
  logic [DW-1:0] mem [256];
  bit            mem_wr [256];
  always @(posedge clk) begin
    if (sram_we) begin
      mem[sram_waddr[7:0]]    <= sram_wdata;
      mem_wr[sram_waddr[7:0]] <= 1'b1;
    end
    sram_rdata <= mem_wr[sram_raddr[7:0]] ? mem[sram_raddr[7:0]] : init_val(sram_raddr[7:0]);
  end

  // Bench-side view of memory contents, updated from the stimulus it drives.
  logic [DW-1:0] shadow [256];
  bit            shadow_wr [256];

  typedef struct {
    int            due;
    logic [2:0]    vld;
    logic [DW-1:0] data;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;

  logic          exp_we;
  logic [AW-1:0] exp_waddr, exp_raddr;
  logic [DW-1:0] exp_wdata;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]           = v;
    req_we[i]              = w;
    req_lock[i]            = l;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_we    = '0;
    req_lock  = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"}, 64'(req_gnt), 64'(0));
    chk({tag, "_we"}, 64'(sram_we), 64'(0));
    chk({tag, "_waddr"}, 64'(sram_waddr), 64'(0));
    chk({tag, "_wdata"}, 64'(sram_wdata), 64'(0));
    chk({tag, "_raddr"}, 64'(sram_raddr), 64'(0));
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'(0));
    chk({tag, "_rsp_data"}, 64'(rsp_data), 64'(0));
  endtask

  // One clock cycle: check grant, SRAM port and read returns, then record what was granted.
  task automatic step(input logic [2:0] exp_gnt);
    exp_t          e;
    int            idx;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    @(negedge clk);
    chk("gnt", 64'(req_gnt), 64'(exp_gnt));
    chk("we", 64'(sram_we), 64'(exp_we));
    chk("waddr", 64'(sram_waddr), 64'(exp_waddr));
    chk("wdata", 64'(sram_wdata), 64'(exp_wdata));
    chk("raddr", 64'(sram_raddr), 64'(exp_raddr));
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      chk("rsp_valid", 64'(rsp_valid), 64'(e.vld));
      chk("rsp_data", 64'(rsp_data), 64'(e.data));
    end else begin
      chk("rsp_idle", 64'(rsp_valid), 64'(0));
    end
    exp_we = 1'b0;
    if (exp_gnt != 3'b000) begin
      idx = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
      a   = req_addr[idx*AW +: AW];
      d   = req_wdata[idx*DW +: DW];
      if (req_we[idx]) begin
        exp_we             = 1'b1;
        exp_waddr          = a;
        exp_wdata          = d;
        shadow[a[7:0]]     = d;
        shadow_wr[a[7:0]]  = 1'b1;
      end else begin
        exp_raddr = a;
        e.due     = cyc + 3;
        e.vld     = exp_gnt;
        e.data    = shadow_wr[a[7:0]] ? shadow[a[7:0]] : init_val(a[7:0]);
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_model();
    sb.delete();
    exp_we    = 1'b0;
    exp_waddr = '0;
    exp_wdata = '0;
    exp_raddr = '0;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_req();
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    chk_zero("por");
    reset_n = 1'b1;

    // Idle bus stays quiet.
    repeat (10) step(3'b000);

    // Round robin across three readers.
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0005, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0006, '0);
    set_req(2, 1'b1, 1'b0, 1'b0, 16'h0007, '0);
    step(3'b001); step(3'b010); step(3'b100);
    step(3'b001); step(3'b010); step(3'b100);
    clear_req();
    repeat (3) step(3'b000);

    // Write then read-back of the same address from another requester.
    set_req(1, 1'b1, 1'b1, 1'b0, 16'h0010, 32'hDEAD_BEEF);
    step(3'b010);
    clear_req();
    set_req(2, 1'b1, 1'b0, 1'b0, 16'h0010, '0);
    step(3'b100);
    clear_req();
    repeat (3) step(3'b000);

    // Locked burst capped at BURST_MAX while requester 2 waits.
    set_req(0, 1'b1, 1'b0, 1'b1, 16'h0020, '0);
    set_req(2, 1'b1, 1'b0, 1'b0, 16'h0021, '0);
    repeat (4) step(3'b001);
    step(3'b100);
    clear_req();
    repeat (3) step(3'b000);

    // Owner keeps the lock while idle; others are locked out.
    set_req(1, 1'b1, 1'b0, 1'b1, 16'h0030, '0);
    step(3'b010);
    set_req(1, 1'b0, 1'b0, 1'b1, 16'h0030, '0);
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0031, '0);
    repeat (3) step(3'b000);
    set_req(1, 1'b1, 1'b0, 1'b1, 16'h0032, '0);
    step(3'b010);
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0033, '0);
    step(3'b010);
    clear_req();
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0031, '0);
    step(3'b001);
    clear_req();
    repeat (3) step(3'b000);

    // Reset with two reads in flight.
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0040, '0);
    step(3'b001);
    clear_req();
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0041, '0);
    step(3'b010);
    clear_req();
    reset_n = 1'b0;
    #1;
    chk_zero("midrst");
    reset_model();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) step(3'b000);
    set_req(0, 1'b1, 1'b0, 1'b0, 16'h0050, '0);
    set_req(1, 1'b1, 1'b0, 1'b0, 16'h0051, '0);
    set_req(2, 1'b1, 1'b0, 1'b0, 16'h0052, '0);
    step(3'b001);
    clear_req();
    repeat (3) step(3'b000);
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
